// File: rtl/bsg_fifo_rolly_replay_seq.sv
// bsg_fifo_rolly_replay_seq: replaying read sequencer for a rollback-capable FIFO.
// Define BSG_FIFO_ROLLY_REPLAY_TIMEOUT_EN to enable the WAIT timeout-as-nack path.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_fifo_rolly_replay_seq #(
    parameter int width_p        = 32,
    parameter int lg_max_beats_p = 4,
    parameter int max_retries_p  = 3,
    parameter int timeout_p      = 255,
    localparam int retry_w_lp    = `BSG_SAFE_CLOG2(max_retries_p + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  fifo_v_i,
    input  logic [width_p-1:0]    fifo_data_i,
    output logic                  fifo_yumi_o,
    output logic                  fifo_rollback_v_o,
    output logic                  fifo_ack_v_o,
    output logic [width_p-1:0]    link_data_o,
    output logic                  link_v_o,
    input  logic                  link_ready_i,
    input  logic                  resp_v_i,
    input  logic                  resp_ok_i,
    output logic                  done_v_o,
    output logic                  err_v_o,
    output logic [retry_w_lp-1:0] retry_cnt_o,
    output logic                  busy_o
);
    typedef enum logic [1:0] {SEND, WAIT, ACK, RB} state_e;

    state_e                    state_r, state_n;
    logic [lg_max_beats_p-1:0] beat_r, beat_n, last_r, last_n, hdr_last;
    logic [retry_w_lp-1:0]     retry_r, retry_n;
    logic                      giveup_r, giveup_n, at_last, nack, timeout;

`ifdef BSG_FIFO_ROLLY_REPLAY_TIMEOUT_EN
    localparam int timer_w_lp = `BSG_SAFE_CLOG2(timeout_p);
    logic [timer_w_lp-1:0] timer_r, timer_n;
    assign timeout = (state_r == WAIT) & (timer_r == timer_w_lp'(timeout_p - 1));
    // held at zero outside WAIT, so entering WAIT always starts a fresh count
    assign timer_n = (state_r != WAIT) ? '0 : timeout ? timer_r : timer_r + 1'b1;
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) timer_r <= '0;
        else timer_r <= timer_n;
`else
    assign timeout = 1'b0;
`endif

    assign link_data_o       = fifo_data_i;
    assign link_v_o          = (state_r == SEND) & fifo_v_i;
    assign fifo_yumi_o       = link_v_o & link_ready_i;
    assign fifo_ack_v_o      = (state_r == ACK);
    assign fifo_rollback_v_o = (state_r == RB);
    assign done_v_o          = (state_r == ACK) & ~giveup_r;
    assign err_v_o           = (state_r == ACK) & giveup_r;
    assign retry_cnt_o       = retry_r;
    assign busy_o            = (state_r != SEND) | (beat_r != '0);

    assign hdr_last = fifo_data_i[lg_max_beats_p-1:0];
    assign at_last  = beat_r == ((beat_r == '0) ? hdr_last : last_r);
    // a real response always beats a coincident timeout
    assign nack     = resp_v_i ? ~resp_ok_i : timeout;

    always_comb begin
        state_n  = state_r;
        beat_n   = beat_r;
        last_n   = last_r;
        retry_n  = retry_r;
        giveup_n = giveup_r;
        case (state_r)
            SEND: if (fifo_yumi_o) begin
                last_n  = (beat_r == '0) ? hdr_last : last_r;
                beat_n  = at_last ? '0 : beat_r + 1'b1;
                state_n = at_last ? WAIT : SEND;
            end
            WAIT: if (resp_v_i & resp_ok_i) begin
                state_n  = ACK;
                giveup_n = 1'b0;
            end else if (nack) begin
                state_n  = (retry_r < retry_w_lp'(max_retries_p)) ? RB : ACK;
                retry_n  = (retry_r < retry_w_lp'(max_retries_p)) ? retry_r + 1'b1 : retry_r;
                giveup_n = (retry_r >= retry_w_lp'(max_retries_p));
            end
            ACK: begin
                state_n  = SEND;
                retry_n  = '0;
                giveup_n = 1'b0;
            end
            default: begin
                state_n = SEND;
                beat_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_r  <= SEND;
            beat_r   <= '0;
            last_r   <= '0;
            retry_r  <= '0;
            giveup_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            beat_r   <= beat_n;
            last_r   <= last_n;
            retry_r  <= retry_n;
            giveup_r <= giveup_n;
        end
endmodule

// File: tb/tb_bsg_fifo_rolly_replay_seq.sv
// tb_bsg_fifo_rolly_replay_seq: directed bench for the replaying FIFO read sequencer.
module tb_bsg_fifo_rolly_replay_seq;
    localparam int W = 32, LG = 2, MR = 2, TO = 8;

    logic clk = 1'b0, rst = 1'b1;
    logic fifo_en = 1'b1, link_ready = 1'b0, resp_v = 1'b0, resp_ok = 1'b0;
    logic fifo_v, yumi, rb_v, ack_v, link_v, done_v, err_v, busy;
    logic [W-1:0] fifo_data, link_data;
    logic [1:0] retry_cnt;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    bsg_fifo_rolly_replay_seq #(.width_p(W), .lg_max_beats_p(LG), .max_retries_p(MR), .timeout_p(TO)) dut (
        .clk_i(clk), .reset_i(rst), .fifo_v_i(fifo_v), .fifo_data_i(fifo_data), .fifo_yumi_o(yumi),
        .fifo_rollback_v_o(rb_v), .fifo_ack_v_o(ack_v), .link_data_o(link_data), .link_v_o(link_v),
        .link_ready_i(link_ready), .resp_v_i(resp_v), .resp_ok_i(resp_ok), .done_v_o(done_v),
        .err_v_o(err_v), .retry_cnt_o(retry_cnt), .busy_o(busy));

    // rollback-capable FIFO model, reset by the same reset as the DUT
    logic [W-1:0] mem [64];
    int wr_ptr = 0, rd_ptr, cmt_ptr;
    assign fifo_v    = fifo_en && (rd_ptr < wr_ptr);
    assign fifo_data = mem[rd_ptr % 64];

    always @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr  <= 0;
            cmt_ptr <= 0;
        end else begin
            if (rb_v) rd_ptr <= cmt_ptr;
            else if (yumi) rd_ptr <= rd_ptr + 1;
            if (ack_v) cmt_ptr <= rd_ptr;
        end

    logic [W-1:0] sent [$];
    int ycyc [$];
    int cyc = 0, rb_n = 0, done_n = 0, err_n = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (yumi) begin
            sent.push_back(link_data);
            ycyc.push_back(cyc);
        end
        if (rb_v) rb_n++;
        if (done_v) done_n++;
        if (err_v) err_n++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [W-1:0] d);
        mem[wr_ptr % 64] = d;
        wr_ptr++;
    endtask

    task automatic respond(input logic ok);
        resp_v = 1'b1;
        resp_ok = ok;
        step();
        resp_v = 1'b0;
    endtask

    task automatic wait_sent(input int n);
        int k = 0;
        while (sent.size() < n && k < 200) begin
            step();
            k++;
        end
        n_cmp++;
        if (sent.size() < n) begin n_err++; $display("FAIL wait_sent: got %0d beats, want %0d", sent.size(), n); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_cmp++; if ({ack_v, rb_v, done_v, err_v, busy, retry_cnt} !== 7'b0) begin n_err++; $display("FAIL reset_hold: got %b want 0", {ack_v, rb_v, done_v, err_v, busy, retry_cnt}); end
        rst = 1'b0;
        step();
        n_cmp++; if ({ack_v, rb_v, done_v, err_v, busy, link_v, yumi, retry_cnt} !== 9'b0) begin n_err++; $display("FAIL reset_release: got %b want 0", {ack_v, rb_v, done_v, err_v, busy, link_v, yumi, retry_cnt}); end
    endtask

    task automatic test_basic();
        int s0 = sent.size();
        link_ready = 1'b1;
        push(32'h0000_0002); push(32'hA1A1_0001); push(32'hA2A2_0002);
        wait_sent(s0 + 3);
        n_cmp++; if (ycyc[s0+2] - ycyc[s0] !== 2) begin n_err++; $display("FAIL basic_consec: got span %0d want 2", ycyc[s0+2] - ycyc[s0]); end
        n_cmp++; if ({sent[s0], sent[s0+1], sent[s0+2]} !== {32'h2, 32'hA1A1_0001, 32'hA2A2_0002}) begin n_err++; $display("FAIL basic_data: got %h %h %h", sent[s0], sent[s0+1], sent[s0+2]); end
        repeat (3) step();
        n_cmp++; if ({busy, ack_v, link_v} !== 3'b100) begin n_err++; $display("FAIL basic_wait: got %b want 100", {busy, ack_v, link_v}); end
        respond(1'b1);
        n_cmp++; if ({ack_v, done_v, err_v, rb_v, retry_cnt} !== 6'b110000) begin n_err++; $display("FAIL basic_ack: got %b want 110000", {ack_v, done_v, err_v, rb_v, retry_cnt}); end
        step();
        n_cmp++; if ({ack_v, done_v, busy} !== 3'b0) begin n_err++; $display("FAIL basic_idle: got %b want 000", {ack_v, done_v, busy}); end
    endtask

    task automatic test_nack_replay();
        int s0 = sent.size();
        push(32'h0000_0002); push(32'hB1B1_0001); push(32'hB2B2_0002);
        wait_sent(s0 + 3);
        respond(1'b0);
        n_cmp++; if ({rb_v, ack_v, retry_cnt} !== 4'b1001) begin n_err++; $display("FAIL nack_rb: got %b want 1001", {rb_v, ack_v, retry_cnt}); end
        step();
        n_cmp++; if ({rb_v, retry_cnt} !== 3'b001) begin n_err++; $display("FAIL nack_replay_retry: got %b want 001", {rb_v, retry_cnt}); end
        wait_sent(s0 + 6);
        n_cmp++; if ({sent[s0+3], sent[s0+4], sent[s0+5]} !== {32'h2, 32'hB1B1_0001, 32'hB2B2_0002}) begin n_err++; $display("FAIL nack_replay_data: got %h %h %h", sent[s0+3], sent[s0+4], sent[s0+5]); end
        respond(1'b1);
        n_cmp++; if ({ack_v, done_v, err_v, rb_v} !== 4'b1100) begin n_err++; $display("FAIL nack_ack: got %b want 1100", {ack_v, done_v, err_v, rb_v}); end
        step();
        n_cmp++; if (retry_cnt !== 2'd0) begin n_err++; $display("FAIL nack_retry_clr: got %0d want 0", retry_cnt); end
    endtask

    task automatic test_give_up();
        int s0 = sent.size(), r0 = rb_n, e0 = err_n, d0 = done_n;
        push(32'hC0DE_0000);
        for (int a = 0; a < 3; a++) begin
            wait_sent(s0 + a + 1);
            respond(1'b0);
            if (a < 2) begin
                n_cmp++; if ({rb_v, retry_cnt} !== {1'b1, 2'(a + 1)}) begin n_err++; $display("FAIL giveup_rb%0d: got %b want %b", a, {rb_v, retry_cnt}, {1'b1, 2'(a + 1)}); end
                step();
            end else begin
                n_cmp++; if ({ack_v, err_v, done_v, rb_v} !== 4'b1100) begin n_err++; $display("FAIL giveup_ack: got %b want 1100", {ack_v, err_v, done_v, rb_v}); end
            end
        end
        step();
        n_cmp++; if ({rb_n - r0, err_n - e0, done_n - d0, sent.size() - s0} !== {32'd2, 32'd1, 32'd0, 32'd3}) begin n_err++; $display("FAIL giveup_counts: rb %0d err %0d done %0d tx %0d want 2 1 0 3", rb_n - r0, err_n - e0, done_n - d0, sent.size() - s0); end
        push(32'h0000_0000);
        wait_sent(s0 + 4);
        n_cmp++; if ({retry_cnt, busy} !== 3'b001) begin n_err++; $display("FAIL giveup_next_retry: got %b want 001", {retry_cnt, busy}); end
        respond(1'b1);
        n_cmp++; if ({done_v, err_v} !== 2'b10) begin n_err++; $display("FAIL giveup_next_done: got %b want 10", {done_v, err_v}); end
        step();
    endtask

    task automatic test_timeout();
        int s0 = sent.size(), r0 = rb_n;
        logic early = 1'b0;
        push(32'h0000_0001); push(32'hD1D1_0001);
        wait_sent(s0 + 2);
`ifdef BSG_FIFO_ROLLY_REPLAY_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            step();
            early |= rb_v;
        end
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL timeout_early: got rollback before cycle 8"); end
        step();
        n_cmp++; if ({rb_v, retry_cnt} !== 3'b101) begin n_err++; $display("FAIL timeout_rb: got %b want 101", {rb_v, retry_cnt}); end
        step();
        wait_sent(s0 + 4);
        repeat (7) step();
        n_cmp++; if (rb_v !== 1'b0) begin n_err++; $display("FAIL timeout_pre: got rb %b want 0", rb_v); end
        respond(1'b1);
        n_cmp++; if ({ack_v, done_v, rb_v, rb_n - r0} !== {3'b110, 32'd1}) begin n_err++; $display("FAIL timeout_race: got ack %b done %b rb %b rbs %0d", ack_v, done_v, rb_v, rb_n - r0); end
`else
        repeat (20) begin
            step();
            early |= rb_v;
        end
        n_cmp++; if ({early, busy} !== 2'b01) begin n_err++; $display("FAIL notimeout_wait: got %b want 01", {early, busy}); end
        respond(1'b1);
        n_cmp++; if ({ack_v, done_v, rb_n - r0} !== {2'b11, 32'd0}) begin n_err++; $display("FAIL notimeout_ack: got ack %b done %b rbs %0d", ack_v, done_v, rb_n - r0); end
`endif
        step();
        n_cmp++; if ({retry_cnt, busy} !== 3'b0) begin n_err++; $display("FAIL timeout_idle: got %b want 000", {retry_cnt, busy}); end
    endtask

    task automatic test_backpressure();
        int s0 = sent.size(), r0 = rb_n, bad = 0;
        push(32'h0000_0003); push(32'hE1E1_0001);
        resp_v = 1'b1;
        resp_ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                resp_v = 1'b0;
                push(32'hE2E2_0002); push(32'hE3E3_0003);
            end
            link_ready = (i % 2 == 0);
            #1;
            if (yumi !== (link_ready && rd_ptr < wr_ptr)) bad++;
            if (i == 7) begin
                n_cmp++; if (sent.size() - s0 !== 2) begin n_err++; $display("FAIL bp_stall: got %0d beats want 2", sent.size() - s0); end
            end
            step();
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_yumi: got %0d bad cycles want 0", bad); end
        n_cmp++; if ({sent[s0], sent[s0+1], sent[s0+2], sent[s0+3]} !== {32'h3, 32'hE1E1_0001, 32'hE2E2_0002, 32'hE3E3_0003}) begin n_err++; $display("FAIL bp_order: got %h %h %h %h", sent[s0], sent[s0+1], sent[s0+2], sent[s0+3]); end
        n_cmp++; if ({rb_n - r0, 30'd0, retry_cnt, busy} !== {32'd0, 30'd0, 2'd0, 1'b1}) begin n_err++; $display("FAIL bp_spurious: rbs %0d retry %0d busy %b want 0 0 1", rb_n - r0, retry_cnt, busy); end
        link_ready = 1'b1;
        respond(1'b1);
        n_cmp++; if ({ack_v, done_v} !== 2'b11) begin n_err++; $display("FAIL bp_ack: got %b want 11", {ack_v, done_v}); end
        step();
    endtask

    task automatic test_async_reset();
        int s0 = sent.size(), r0 = rb_n;
        push(32'h0000_0003); push(32'hF1F1_0001); push(32'hF2F2_0002); push(32'hF3F3_0003);
        wait_sent(s0 + 2);
        #1;
        rst = 1'b1;
        wr_ptr = 0;
        #1;
        n_cmp++; if ({ack_v, rb_v, done_v, err_v, busy, link_v, yumi, retry_cnt} !== 9'b0) begin n_err++; $display("FAIL areset_now: got %b want 0", {ack_v, rb_v, done_v, err_v, busy, link_v, yumi, retry_cnt}); end
        step();
        step();
        rst = 1'b0;
        step();
        n_cmp++; if ({busy, link_v, retry_cnt, rb_n - r0} !== {4'b0, 32'd0}) begin n_err++; $display("FAIL areset_after: busy %b link_v %b retry %0d rbs %0d", busy, link_v, retry_cnt, rb_n - r0); end
        s0 = sent.size();
        push(32'h0000_0000);
        wait_sent(s0 + 1);
        respond(1'b1);
        n_cmp++; if ({ack_v, done_v, sent[s0]} !== {2'b11, 32'h0}) begin n_err++; $display("FAIL areset_next: ack %b done %b hdr %h", ack_v, done_v, sent[s0]); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_nack_replay();
        test_give_up();
        test_timeout();
        test_backpressure();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
